// File: rtl/vram_arbiter_m_if.sv
// rtl/vram_arbiter_m_if.sv - CPU/fill request and VRAM write-port bundle for vram_arbiter_m
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

interface vram_arbiter_m_if #(
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  write_window;
    logic                  cpu_valid;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [7:0]            cpu_data;
    logic                  cpu_ready;
    logic                  fill_valid;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic [7:0]            fill_data;
    logic                  fill_ready;
    logic [ADDR_WIDTH-1:0] vram_address;
    logic [7:0]            vram_data;
    logic                  vram_write_enable;
    logic [LVL_W-1:0]      fifo_level;

    modport master (
        output write_window, cpu_valid, cpu_address, cpu_data,
        output fill_valid, fill_address, fill_data,
        input  cpu_ready, fill_ready,
        input  vram_address, vram_data, vram_write_enable, fifo_level
    );

    modport slave (
        input  write_window, cpu_valid, cpu_address, cpu_data,
        input  fill_valid, fill_address, fill_data,
        output cpu_ready, fill_ready,
        output vram_address, vram_data, vram_write_enable, fifo_level
    );
endinterface

// File: rtl/vram_arbiter_m.sv
// rtl/vram_arbiter_m.sv - round-robin CPU/fill arbiter for the GPU VRAM write port; CPU post FIFO under VRAM_ARB_CPU_FIFO_EN
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_arbiter_m #(
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_12_5875,
    input  logic            rst_n,
    vram_arbiter_m_if.slave bus
);
    localparam int   LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic SRC_CPU  = 1'b0;
    localparam logic SRC_FILL = 1'b1;

    logic                  cpu_pend;
    logic [ADDR_WIDTH-1:0] cpu_src_addr;
    logic [7:0]            cpu_src_data;
    logic                  gnt_cpu;
    logic                  gnt_fill;

    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] vram_address_q, vram_address_d;
    logic [7:0]            vram_data_q, vram_data_d;
    logic                  vram_we_q, vram_we_d;

`ifdef VRAM_ARB_CPU_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_WIDTH+7:0] fifo_mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH+7:0] fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  fifo_full;
    logic                  push;

    // No full-bypass: a pop in the same cycle does not reopen cpu_ready.
    assign fifo_full       = (level_q == LVL_W'(FIFO_DEPTH));
    assign bus.cpu_ready   = rst_n & ~fifo_full;
    assign push            = bus.cpu_valid & bus.cpu_ready;
    assign cpu_pend        = (level_q != '0);
    assign {cpu_src_addr, cpu_src_data} = fifo_mem_q[rd_ptr_q];
    assign bus.fifo_level  = level_q;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {bus.cpu_address, bus.cpu_data};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (gnt_cpu) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !gnt_cpu) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && gnt_cpu) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_12_5875) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
`else
    // Without the FIFO the CPU stalls on the bus until it wins a grant.
    assign cpu_pend       = bus.cpu_valid;
    assign cpu_src_addr   = bus.cpu_address;
    assign cpu_src_data   = bus.cpu_data;
    assign bus.cpu_ready  = rst_n & gnt_cpu;
    assign bus.fifo_level = LVL_W'(0);
`endif

    always_comb begin
        gnt_cpu  = 1'b0;
        gnt_fill = 1'b0;
        if (bus.write_window) begin
            if (cpu_pend && bus.fill_valid) begin
                if (last_grant_q == SRC_CPU) begin
                    gnt_fill = 1'b1;
                end else begin
                    gnt_cpu = 1'b1;
                end
            end else begin
                gnt_cpu  = cpu_pend;
                gnt_fill = bus.fill_valid;
            end
        end
    end

    assign bus.fill_ready = gnt_fill;

    always_comb begin
        last_grant_d   = last_grant_q;
        vram_we_d      = gnt_cpu | gnt_fill;
        vram_address_d = vram_address_q;
        vram_data_d    = vram_data_q;
        if (gnt_cpu) begin
            last_grant_d   = SRC_CPU;
            vram_address_d = cpu_src_addr;
            vram_data_d    = cpu_src_data;
        end else if (gnt_fill) begin
            last_grant_d   = SRC_FILL;
            vram_address_d = bus.fill_address;
            vram_data_d    = bus.fill_data;
        end
    end

    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= SRC_CPU;
            vram_we_q      <= 1'b0;
            vram_address_q <= '0;
            vram_data_q    <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            vram_we_q      <= vram_we_d;
            vram_address_q <= vram_address_d;
            vram_data_q    <= vram_data_d;
        end
    end

    assign bus.vram_address      = vram_address_q;
    assign bus.vram_data         = vram_data_q;
    assign bus.vram_write_enable = vram_we_q;
endmodule

// File: tb/tb_vram_arbiter_m.sv
// tb/tb_vram_arbiter_m.sv - scoreboard bench for vram_arbiter_m
module tb_vram_arbiter_m;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_m_if #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

    vram_arbiter_m #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_12_5875 (clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [AW+7:0] exp_q [$];
    logic [7:0]    fdat  [5] = '{8'h0F, 8'h0F, 8'h00, 8'h07, 8'h01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [AW+7:0] ent(input int a, input int d);
        return {a[AW-1:0], d[7:0]};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Every observed VRAM write must match the oldest expected write.
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (rst_n && bus.vram_write_enable) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_we", bus.vram_write_enable, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", bus.vram_address, e[AW+7:8]);
                check("sb_data", bus.vram_data, e[7:0]);
            end
        end
    end

    initial begin
        int   fill_n;
        int   cpu_n;
        logic exp_fill;

        bus.write_window = 1'b1;
        bus.cpu_valid    = 1'b1;
        bus.cpu_address  = 12'h0AA;
        bus.cpu_data     = 8'h55;
        bus.fill_valid   = 1'b0;
        bus.fill_address = '0;
        bus.fill_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", bus.vram_write_enable, 1'b0);
        check("rst_addr", bus.vram_address, 12'h000);
        check("rst_data", bus.vram_data, 8'h00);
        check("rst_level", bus.fifo_level, 0);
        check("rst_cpu_ready", bus.cpu_ready, 1'b0);
        next();
        bus.cpu_valid    = 1'b0;
        bus.write_window = 1'b0;
        rst_n            = 1'b1;
        next();

        // Tie: fill wins first after reset, then strict alternation.
`ifdef VRAM_ARB_CPU_FIFO_EN
        for (int k = 0; k < 2; k++) begin
            bus.cpu_valid   = 1'b1;
            bus.cpu_address = 12'(12'h200 + k);
            bus.cpu_data    = 8'(8'h50 + k);
            @(negedge clk);
            check("tie_post_rdy", bus.cpu_ready, 1'b1);
            next();
        end
        bus.cpu_valid = 1'b0;
`endif
        bus.write_window = 1'b1;
        bus.fill_valid   = 1'b1;
        fill_n = 0;
        cpu_n  = 0;
        for (int k = 0; k < 4; k++) begin
            exp_fill         = (k % 2 == 0);
            bus.fill_address = 12'(12'h100 + fill_n);
            bus.fill_data    = 8'(8'hA0 + fill_n);
`ifndef VRAM_ARB_CPU_FIFO_EN
            bus.cpu_valid    = 1'b1;
            bus.cpu_address  = 12'(12'h200 + cpu_n);
            bus.cpu_data     = 8'(8'h50 + cpu_n);
`endif
            @(negedge clk);
            check("tie_fill_rdy", bus.fill_ready, exp_fill);
`ifndef VRAM_ARB_CPU_FIFO_EN
            check("tie_cpu_rdy", bus.cpu_ready, !exp_fill);
`endif
            if (exp_fill) begin
                exp_q.push_back(ent(12'h100 + fill_n, 8'hA0 + fill_n));
                fill_n++;
            end else begin
                exp_q.push_back(ent(12'h200 + cpu_n, 8'h50 + cpu_n));
                cpu_n++;
            end
            next();
        end
        bus.fill_valid   = 1'b0;
        bus.cpu_valid    = 1'b0;
        bus.write_window = 1'b0;
        next();
        check("tie_sb_empty", exp_q.size(), 0);

        // Fill only: one write per cycle, each one cycle after acceptance.
        bus.write_window = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.fill_valid   = 1'b1;
            bus.fill_address = 12'(k);
            bus.fill_data    = 8'h0F;
            @(negedge clk);
            check("fill_rdy", bus.fill_ready, 1'b1);
            if (k > 0) begin
                check("fill_we", bus.vram_write_enable, 1'b1);
                check("fill_lat_addr", bus.vram_address, k - 1);
            end
            exp_q.push_back(ent(k, 8'h0F));
            next();
        end
        bus.fill_valid = 1'b0;
        @(negedge clk);
        check("fill_we_last", bus.vram_write_enable, 1'b1);
        check("fill_addr_last", bus.vram_address, 12'h007);
        next();
        @(negedge clk);
        check("fill_idle_we", bus.vram_write_enable, 1'b0);
        check("hold_addr", bus.vram_address, 12'h007);
        check("hold_data", bus.vram_data, 8'h0F);
        next();

        // Window close right after a grant: that write still lands, then nothing.
        bus.fill_valid   = 1'b1;
        bus.fill_address = 12'h0A0;
        bus.fill_data    = 8'h5A;
        @(negedge clk);
        check("wc_rdy_open", bus.fill_ready, 1'b1);
        exp_q.push_back(ent(12'h0A0, 8'h5A));
        next();
        bus.write_window = 1'b0;
        bus.fill_address = 12'h0A1;
        bus.fill_data    = 8'h5B;
        @(negedge clk);
        check("wc_rdy_closed", bus.fill_ready, 1'b0);
        check("wc_we", bus.vram_write_enable, 1'b1);
        check("wc_addr", bus.vram_address, 12'h0A0);
        next();
        @(negedge clk);
        check("wc_we_off", bus.vram_write_enable, 1'b0);
        check("wc_rdy_still", bus.fill_ready, 1'b0);
        next();
        bus.fill_valid = 1'b0;

`ifdef VRAM_ARB_CPU_FIFO_EN
        // Post five with the window closed; the fifth waits for space.
        for (int k = 0; k < 5; k++) begin
            bus.cpu_valid   = 1'b1;
            bus.cpu_address = 12'(12'h800 + k);
            bus.cpu_data    = fdat[k];
            @(negedge clk);
            check("fifo_level_post", bus.fifo_level, (k < 4) ? k : 4);
            check("fifo_rdy_post", bus.cpu_ready, k < 4);
            if (k < 4) next();
        end
        next();
        bus.write_window = 1'b1;
        @(negedge clk);
        check("fifo_nobypass", bus.cpu_ready, 1'b0);
        check("fifo_level_full", bus.fifo_level, 4);
        for (int k = 0; k < 5; k++) exp_q.push_back(ent(12'h800 + k, fdat[k]));
        next();
        @(negedge clk);
        check("fifo_rdy_reopen", bus.cpu_ready, 1'b1);
        check("fifo_level_pp", bus.fifo_level, 3);
        check("fifo_drain_we0", bus.vram_write_enable, 1'b1);
        check("fifo_drain_addr0", bus.vram_address, 12'h800);
        next();
        bus.cpu_valid = 1'b0;
        for (int j = 1; j < 5; j++) begin
            @(negedge clk);
            check("fifo_drain_we", bus.vram_write_enable, 1'b1);
            check("fifo_drain_addr", bus.vram_address, 12'h800 + j);
            check("fifo_drain_level", bus.fifo_level, 4 - j);
            next();
        end
        @(negedge clk);
        check("fifo_done_we", bus.vram_write_enable, 1'b0);
        check("fifo_done_level", bus.fifo_level, 0);
        next();
        bus.write_window = 1'b0;

        // Reset mid-drain discards the posted entries not yet written.
        for (int k = 0; k < 3; k++) begin
            bus.cpu_valid   = 1'b1;
            bus.cpu_address = 12'(12'h700 + k);
            bus.cpu_data    = 8'(8'h11 * (k + 1));
            @(negedge clk);
            check("rm_post_rdy", bus.cpu_ready, 1'b1);
            next();
        end
        bus.cpu_valid    = 1'b0;
        bus.write_window = 1'b1;
        @(negedge clk);
        check("rm_level3", bus.fifo_level, 3);
        exp_q.push_back(ent(12'h700, 8'h11));
        next();
        @(negedge clk);
        check("rm_first_we", bus.vram_write_enable, 1'b1);
        next();
        rst_n = 1'b0;
`else
        // Without FIFO the CPU stalls until the window opens.
        bus.cpu_valid   = 1'b1;
        bus.cpu_address = 12'h300;
        bus.cpu_data    = 8'h3C;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("nf_rdy_closed", bus.cpu_ready, 1'b0);
            check("nf_level", bus.fifo_level, 0);
            next();
        end
        bus.write_window = 1'b1;
        @(negedge clk);
        check("nf_rdy_open", bus.cpu_ready, 1'b1);
        exp_q.push_back(ent(12'h300, 8'h3C));
        next();
        bus.cpu_valid = 1'b0;
        @(negedge clk);
        check("nf_we", bus.vram_write_enable, 1'b1);
        check("nf_addr", bus.vram_address, 12'h300);
        next();

        // Reset kills a write that was just loaded into the output register.
        bus.fill_valid   = 1'b1;
        bus.fill_address = 12'h3FF;
        bus.fill_data    = 8'hEE;
        @(negedge clk);
        check("rm_fill_rdy", bus.fill_ready, 1'b1);
        next();
        bus.fill_valid = 1'b0;
        rst_n          = 1'b0;
`endif
        @(negedge clk);
        check("rm_level", bus.fifo_level, 0);
        check("rm_we", bus.vram_write_enable, 1'b0);
        check("rm_addr", bus.vram_address, 12'h000);
        check("rm_data", bus.vram_data, 8'h00);
        check("rm_cpu_ready", bus.cpu_ready, 1'b0);
        next();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rm_after_we", bus.vram_write_enable, 1'b0);
            check("rm_after_level", bus.fifo_level, 0);
            next();
        end
        bus.write_window = 1'b0;
        next();
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
